// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin arbiter: shares one AXI-Stream sink between NUM_PORTS sources,
// holding each grant from a packet's first beat through its tlast beat.
//
//   state  | meaning
//   IDLE   | no grant; scan requesters starting after grant_idx, latch winner
//   LOCKED | port grant_idx passed straight through to the sink until tlast handshake
module axis_rr_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 8,
   parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
   parameter int USER_WIDTH = 1,
   parameter int DEST_WIDTH = 8,
   parameter int ID_WIDTH   = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_tdata,
   input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_tkeep,
   input  logic [NUM_PORTS*USER_WIDTH-1:0]  s_tuser,
   input  logic [NUM_PORTS*DEST_WIDTH-1:0]  s_tdest,
   input  logic [NUM_PORTS-1:0]             s_tlast,
   input  logic [NUM_PORTS-1:0]             s_tvalid,
   output logic [NUM_PORTS-1:0]             s_tready,
   output logic [DATA_WIDTH-1:0]            m_tdata,
   output logic [KEEP_WIDTH-1:0]            m_tkeep,
   output logic [USER_WIDTH-1:0]            m_tuser,
   output logic [DEST_WIDTH-1:0]            m_tdest,
   output logic [ID_WIDTH-1:0]              m_tid,
   output logic                             m_tlast,
   output logic                             m_tvalid,
   input  logic                             m_tready,
   output logic                             grant_active,
   output logic [$clog2(NUM_PORTS)-1:0]     grant_idx
);

   localparam int IDX_W = $clog2(NUM_PORTS);

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] next_idx;
   logic             any_req;
   int               scan_p;

   // Walk offsets from farthest to nearest so the nearest requester after grant_idx wins;
   // offset NUM_PORTS is the previous winner itself, hence lowest priority.
   always_comb begin
      next_idx = grant_idx;
      any_req  = 1'b0;
      scan_p   = 0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         scan_p = (int'(grant_idx) + k) % NUM_PORTS;
         if (s_tvalid[scan_p]) begin
            next_idx = IDX_W'(scan_p);
            any_req  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         grant_idx    <= IDX_W'(NUM_PORTS - 1);
         grant_active <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  grant_idx    <= next_idx;
                  state        <= LOCKED;
                  grant_active <= 1'b1;
               end
            end
            LOCKED: begin
               if (m_tvalid && m_tready && m_tlast) begin
                  state        <= IDLE;
                  grant_active <= 1'b0;
               end
            end
            default: begin
               state        <= IDLE;
               grant_active <= 1'b0;
            end
         endcase
      end
   end

   // Zero-latency passthrough of the granted port; everything parks at zero outside LOCKED.
   always_comb begin
      m_tdata  = '0;
      m_tkeep  = '0;
      m_tuser  = '0;
      m_tdest  = '0;
      m_tlast  = 1'b0;
      m_tvalid = 1'b0;
      s_tready = '0;
      if (state == LOCKED) begin
         m_tdata             = s_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
         m_tkeep             = s_tkeep[grant_idx*KEEP_WIDTH +: KEEP_WIDTH];
         m_tuser             = s_tuser[grant_idx*USER_WIDTH +: USER_WIDTH];
         m_tdest             = s_tdest[grant_idx*DEST_WIDTH +: DEST_WIDTH];
         m_tlast             = s_tlast[grant_idx];
         m_tvalid            = s_tvalid[grant_idx];
         s_tready[grant_idx] = m_tready;
      end
   end

   assign m_tid = ID_WIDTH'(grant_idx);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Directed bench for axis_rr_arbiter: queue-driven AXIS sources, per-port expected-beat
// scoreboard checked on every sink handshake, plus per-step protocol checks.
module tb_axis_rr_arbiter;

   localparam int NP = 4;
   localparam int DW = 8;
   localparam int KW = 1;
   localparam int UW = 1;
   localparam int TW = 8;
   localparam int IW = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [NP*DW-1:0] s_tdata  = '0;
   logic [NP*KW-1:0] s_tkeep  = '0;
   logic [NP*UW-1:0] s_tuser  = '0;
   logic [NP*TW-1:0] s_tdest  = '0;
   logic [NP-1:0]    s_tlast  = '0;
   logic [NP-1:0]    s_tvalid = '0;
   logic [NP-1:0]    s_tready;
   logic [DW-1:0]    m_tdata;
   logic [KW-1:0]    m_tkeep;
   logic [UW-1:0]    m_tuser;
   logic [TW-1:0]    m_tdest;
   logic [IW-1:0]    m_tid;
   logic             m_tlast;
   logic             m_tvalid;
   logic             m_tready = 1'b1;
   logic             grant_active;
   logic [1:0]       grant_idx;

   axis_rr_arbiter #(
      .NUM_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
      .USER_WIDTH(UW), .DEST_WIDTH(TW), .ID_WIDTH(IW)
   ) dut (
      .clk(clk), .rst(rst),
      .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tuser(s_tuser), .s_tdest(s_tdest),
      .s_tlast(s_tlast), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tdest(m_tdest),
      .m_tid(m_tid), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
      .grant_active(grant_active), .grant_idx(grant_idx)
   );

   int checks = 0;
   int errors = 0;

   // beat = {last, data}
   logic [8:0] src_q [NP][$];
   logic [8:0] exp_q [NP][$];
   bit         src_en [NP];
   bit         hs [NP];
   int         grant_log [$];
   bit         in_pkt = 1'b0;
   int         cur_tid = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit all_empty();
      bit e = 1'b1;
      for (int i = 0; i < NP; i++)
         if (src_q[i].size() != 0 || exp_q[i].size() != 0) e = 1'b0;
      return e;
   endfunction

   task automatic load(input int p, input logic [7:0] base, input int n);
      logic [8:0] b9;
      for (int b = 0; b < n; b++) begin
         b9 = {(b == n - 1), 8'(base + 8'(b))};
         src_q[p].push_back(b9);
         exp_q[p].push_back(b9);
      end
   endtask

   // Pop beats handshaken at the edge just passed, then present each port's next beat.
   task automatic drive_src();
      logic [8:0] f;
      bit         v;
      for (int i = 0; i < NP; i++) begin
         if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         v = src_en[i] && (src_q[i].size() > 0);
         f = v ? src_q[i][0] : 9'h0;
         s_tvalid[i]           = v;
         s_tlast[i]            = f[8];
         s_tdata[i*DW +: DW]   = f[7:0];
         s_tkeep[i*KW +: KW]   = KW'(v);
         s_tuser[i*UW +: UW]   = UW'(i % 2);
         s_tdest[i*TW +: TW]   = 8'h10 + 8'(i);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drive_src();
      #1;
   endtask

   task automatic tick_rdy(input logic r);
      @(posedge clk);
      #1;
      drive_src();
      m_tready = r;
      #1;
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while (!all_empty() && n < 300) begin
         tick();
         n++;
      end
      chk(tag, 32'(all_empty()), 32'd1);
   endtask

   // Sink monitor: scoreboard pop on every handshake, interleave and ready-exclusivity checks.
   int         mon_t;
   logic [8:0] mon_e;
   always @(negedge clk) begin
      for (int i = 0; i < NP; i++) hs[i] = s_tvalid[i] & s_tready[i];
      if (!rst) begin
         in_pkt = 1'b0;
      end else begin
         chk("ready_onehot", 32'($countones(s_tready) <= 1), 32'd1);
         if (m_tvalid && m_tready) begin
            mon_t = int'(m_tid);
            if (in_pkt) chk("interleave_tid", 32'(mon_t), 32'(cur_tid));
            else begin
               grant_log.push_back(mon_t);
               in_pkt  = 1'b1;
               cur_tid = mon_t;
            end
            if (mon_t < NP && exp_q[mon_t].size() > 0) begin
               mon_e = exp_q[mon_t].pop_front();
               chk("beat_data", 32'(m_tdata), 32'(mon_e[7:0]));
               chk("beat_last", 32'(m_tlast), 32'(mon_e[8]));
               chk("beat_dest", 32'(m_tdest), 32'(8'h10 + 8'(mon_t)));
               chk("beat_keep", 32'(m_tkeep), 32'd1);
            end else begin
               chk("stray_beat_tid", 32'(m_tid), 32'hFFFF_FFFF);
            end
            if (m_tlast) in_pkt = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int bi;
      logic r;
      int exp_ord3 [6];
      int exp_ord1 [4];
      exp_ord3 = '{0, 1, 3, 0, 1, 3};
      exp_ord1 = '{0, 1, 2, 3};
      for (int i = 0; i < NP; i++) src_en[i] = 1'b1;

      // 1: reset with every port requesting, then port 0 first; full wrap 0..3
      for (int p = 0; p < NP; p++) load(p, 8'hC0 + 8'(p), 1);
      tick();
      tick();
      chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_s_tready", 32'(s_tready), 32'd0);
      chk("rst_grant_active", 32'(grant_active), 32'd0);
      chk("rst_grant_idx", 32'(grant_idx), 32'd3);
      chk("rst_m_tid", 32'(m_tid), 32'd3);
      rst = 1'b1;
      tick();
      chk("t1_grant_active", 32'(grant_active), 32'd1);
      chk("t1_grant_idx", 32'(grant_idx), 32'd0);
      chk("t1_m_tdata", 32'(m_tdata), 32'hC0);
      drain("t1_drain");
      chk("t1_log_size", 32'(grant_log.size()), 32'd4);
      for (int k = 0; k < 4 && k < grant_log.size(); k++)
         chk("t1_order", 32'(grant_log[k]), 32'(exp_ord1[k]));

      // 3: ports 0,1,3 with back-to-back 2-beat packets
      grant_log.delete();
      for (int k = 0; k < 2; k++) begin
         load(0, 8'h00 + 8'(k * 2), 2);
         load(1, 8'h10 + 8'(k * 2), 2);
         load(3, 8'h30 + 8'(k * 2), 2);
      end
      drain("t3_drain");
      chk("t3_log_size", 32'(grant_log.size()), 32'd6);
      for (int k = 0; k < 6 && k < grant_log.size(); k++)
         chk("t3_order", 32'(grant_log[k]), 32'(exp_ord3[k]));

      // 2: single port 2, 3-beat packet then 1-beat packet, one bubble between
      load(2, 8'hA1, 3);
      load(2, 8'hB1, 1);
      tick();
      chk("t2_idle_no_beat", 32'(m_tvalid), 32'd0);
      for (int b = 0; b < 3; b++) begin
         tick();
         chk("t2_data", 32'(m_tdata), 32'(8'hA1 + 8'(b)));
         chk("t2_tid", 32'(m_tid), 32'd2);
         chk("t2_last", 32'(m_tlast), 32'(b == 2));
      end
      tick();
      chk("t2_bubble_valid", 32'(m_tvalid), 32'd0);
      chk("t2_bubble_active", 32'(grant_active), 32'd0);
      chk("t2_bubble_tid", 32'(m_tid), 32'd2);
      chk("t2_bubble_data", 32'(m_tdata), 32'd0);
      tick();
      chk("t2_regrant_active", 32'(grant_active), 32'd1);
      chk("t2_regrant_data", 32'(m_tdata), 32'hB1);
      drain("t2_drain");

      // 4: backpressure on a 4-beat packet from port 1 while port 2 waits
      load(1, 8'hD0, 4);
      load(2, 8'hE0, 1);
      tick_rdy(1'b1);
      bi = 0;
      for (int c = 0; c < 7; c++) begin
         r = (c % 2 == 0);
         tick_rdy(r);
         chk("t4_tid", 32'(m_tid), 32'd1);
         chk("t4_valid", 32'(m_tvalid), 32'd1);
         chk("t4_data", 32'(m_tdata), 32'(8'hD0 + 8'(bi)));
         chk("t4_last", 32'(m_tlast), 32'(bi == 3));
         chk("t4_s_tready", 32'(s_tready), 32'({2'b00, r, 1'b0}));
         if (r) bi++;
      end
      m_tready = 1'b1;
      drain("t4_drain");

      // 5: port 0 stalls mid-packet for 5 cycles; port 1 must wait
      load(0, 8'hF0, 4);
      load(1, 8'h60, 1);
      tick();
      tick();
      chk("t5_grant_tid", 32'(m_tid), 32'd0);
      tick();
      chk("t5_beat2", 32'(m_tdata), 32'hF1);
      src_en[0] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t5_hold_valid", 32'(m_tvalid), 32'd0);
         chk("t5_hold_active", 32'(grant_active), 32'd1);
         chk("t5_hold_tid", 32'(m_tid), 32'd0);
         chk("t5_hold_ready", 32'(s_tready), 32'b0001);
      end
      src_en[0] = 1'b1;
      tick();
      chk("t5_resume", 32'(m_tdata), 32'hF2);
      tick();
      chk("t5_tail_last", 32'(m_tlast), 32'd1);
      tick();
      chk("t5_bubble", 32'(grant_active), 32'd0);
      tick();
      chk("t5_port1_tid", 32'(m_tid), 32'd1);
      drain("t5_drain");

      // 6: asynchronous reset after beat 2 of 4
      load(1, 8'h70, 4);
      tick();
      tick();
      tick();
      tick();
      chk("t6_pre_rst", 32'(m_tdata), 32'h72);
      rst = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(m_tvalid), 32'd0);
      chk("t6_rst_ready", 32'(s_tready), 32'd0);
      chk("t6_rst_active", 32'(grant_active), 32'd0);
      chk("t6_rst_idx", 32'(grant_idx), 32'd3);
      chk("t6_rst_data", 32'(m_tdata), 32'd0);
      src_q[1].delete();
      exp_q[1].delete();
      load(0, 8'h80, 1);
      load(1, 8'h90, 1);
      load(3, 8'hA0, 1);
      tick();
      chk("t6_in_rst_valid", 32'(m_tvalid), 32'd0);
      rst = 1'b1;
      tick();
      chk("t6_first_idx", 32'(grant_idx), 32'd0);
      chk("t6_first_data", 32'(m_tdata), 32'h80);
      drain("t6_drain");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
